// File: rtl/key_led_ctrl.sv
// Debounced two-key mode controller driving an LED bank.
// Modes: BLINK, FREEZE (hold entry value), ON, OFF; key 0 steps forward, key 1 steps back.
module key_led_ctrl #(
    parameter int CLK_FREQ    = 27_000_000,
    parameter int KEY_NUM     = 2,
    parameter int LED_NUM     = 6,
    parameter int DEBOUNCE_MS = 20,
    parameter int BLINK_MS    = 500
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [KEY_NUM-1:0] key,
    output logic [LED_NUM-1:0] led_o,
    output logic [1:0]         mode_o,
    output logic [KEY_NUM-1:0] key_evt_o
);

    localparam int D  = (CLK_FREQ / 1000) * DEBOUNCE_MS;
    localparam int B  = (CLK_FREQ / 1000) * BLINK_MS;
    localparam int CW = (D > 1) ? $clog2(D) : 1;
    localparam int BW = (B > 1) ? $clog2(B) : 1;

    typedef enum logic [1:0] {
        MODE_BLINK  = 2'd0,
        MODE_FREEZE = 2'd1,
        MODE_ON     = 2'd2,
        MODE_OFF    = 2'd3
    } mode_e;

    logic [KEY_NUM-1:0] sync1_q, sync2_q;
    logic [KEY_NUM-1:0] stable_q, stable_d;
    logic [CW-1:0]      cnt_q [KEY_NUM];
    logic [CW-1:0]      cnt_d [KEY_NUM];
    logic [KEY_NUM-1:0] evt_q, evt_d;
    mode_e              mode_q, mode_d;
    logic [BW-1:0]      bcnt_q, bcnt_d;
    logic [LED_NUM-1:0] ph_q, ph_d;
    logic [LED_NUM-1:0] led_q, led_d;
    logic               blink_entry;

    // A key's debounced level flips only after D consecutive disagreeing samples.
    always_comb begin
        stable_d = stable_q;
        evt_d    = '0;
        for (int i = 0; i < KEY_NUM; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CW'(D - 1)) begin
                    stable_d[i] = sync2_q[i];
                    evt_d[i]    = ~sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        mode_d = mode_q;
        unique case ({evt_q[1], evt_q[0]})
            2'b01:   mode_d = mode_e'(mode_q + 2'd1);
            2'b10:   mode_d = mode_e'(mode_q - 2'd1);
            default: mode_d = mode_q;
        endcase
    end

    assign blink_entry = (mode_d == MODE_BLINK) && (mode_q != MODE_BLINK);

    always_comb begin
        bcnt_d = bcnt_q + 1'b1;
        ph_d   = ph_q;
        if (blink_entry) begin
            bcnt_d = '0;
            ph_d   = '1;
        end else if (bcnt_q == BW'(B - 1)) begin
            bcnt_d = '0;
            ph_d   = ~ph_q;
        end
    end

    // LEDs follow the next mode so they change on the same edge as mode_o.
    always_comb begin
        led_d = led_q;
        unique case (mode_d)
            MODE_BLINK:  led_d = ph_d;
            MODE_FREEZE: led_d = led_q;
            MODE_ON:     led_d = '1;
            MODE_OFF:    led_d = '0;
            default:     led_d = led_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= '1;
            sync2_q  <= '1;
            stable_q <= '1;
            for (int i = 0; i < KEY_NUM; i++) begin
                cnt_q[i] <= '0;
            end
            evt_q    <= '0;
            mode_q   <= MODE_BLINK;
            bcnt_q   <= '0;
            ph_q     <= '1;
            led_q    <= '1;
        end else begin
            sync1_q  <= key;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            evt_q    <= evt_d;
            mode_q   <= mode_d;
            bcnt_q   <= bcnt_d;
            ph_q     <= ph_d;
            led_q    <= led_d;
        end
    end

    assign led_o     = led_q;
    assign mode_o    = mode_q;
    assign key_evt_o = evt_q;

endmodule

// File: doc/key_led_ctrl.md
KEY_LED_CTRL -- requirements
Module: key_led_ctrl

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 27_000_000, meaning clk frequency in Hz (minimum 1000).
REQ-002 SHALL have parameter KEY_NUM, default 2, meaning number of keys (2..8).
REQ-003 SHALL have parameter LED_NUM, default 6, meaning number of LED outputs (1..32).
REQ-004 SHALL have parameter DEBOUNCE_MS, default 20, meaning debounce window in ms (at least 1).
REQ-005 SHALL have parameter BLINK_MS, default 500, meaning blink half-period in ms (at least 1).
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port key, input, KEY_NUM bits: raw asynchronous keys, active-low (0 = pressed).
REQ-009 SHALL have port led_o, output, LED_NUM bits: LED drive, 1 = lit.
REQ-010 SHALL have port mode_o, output, 2 bits: current mode (0 BLINK, 1 FREEZE, 2 ON, 3 OFF).
REQ-011 SHALL have port key_evt_o, output, KEY_NUM bits: one-cycle debounced press pulse per key.

Function
REQ-012 SHALL define the constants D = (CLK_FREQ/1000)*DEBOUNCE_MS and B = (CLK_FREQ/1000)*BLINK_MS, each in cycles; counter widths SHALL be sized with $clog2 of these.
REQ-013 SHALL synchronise each key bit through a 2-flop synchroniser before any further use.
REQ-014 SHALL keep, per key, a debounced state `stable` (1 = released) and a counter `cnt`.
- The counter SHALL increment while sync != stable.
- The counter SHALL clear to 0 on any cycle where sync == stable.
REQ-015 SHALL act on the edge where sync != stable and cnt == D-1:
- stable takes the value of sync;
- cnt clears to 0;
- if the new stable is 0 (pressed), key_evt_o[i] goes high for exactly that one cycle.
REQ-016 SHALL give a latency from key[i] falling to key_evt_o[i] high of exactly D+2 cycles, counted from the first edge that samples key low, provided the key stays low throughout.
REQ-017 SHALL treat a raw glitch shorter than D cycles as producing no event; release SHALL produce no event.
REQ-018 SHALL drive the mode FSM from the key events:
- key_evt_o[0] alone advances the mode: BLINK->FREEZE->ON->OFF->BLINK (wrap).
- key_evt_o[1] alone steps the mode back: BLINK->OFF->ON->FREEZE->BLINK.
REQ-019 SHALL leave the mode unchanged when key_evt_o[0] and key_evt_o[1] are high in the same cycle; key bits 2 and up SHALL affect only key_evt_o.
REQ-020 SHALL run the blink counter `bcnt` from 0 to B-1 and then wrap to 0; the wrap cycle SHALL toggle the blink phase register `ph` (LED_NUM bits, all bits equal).
REQ-021 SHALL reset bcnt to 0 and set ph to all-ones on the cycle the mode changes into BLINK.
REQ-022 SHALL select led_o, registered, by mode:
- BLINK: led_o = ph.
- FREEZE: led_o holds the value it had on entry.
- ON: led_o = all ones.
- OFF: led_o = all zeros.
REQ-023 SHALL update mode_o and led_o one cycle after the key_evt_o pulse that caused the mode change.
REQ-024 SHALL keep the blink counter running in all modes except on BLINK entry (REQ-021).

Reset
REQ-025 SHALL, while rst is high at a clk edge, set the following, taking effect at that edge:
- synchroniser flops to 1;
- stable to all ones;
- cnt, bcnt and key_evt_o to 0;
- mode_o to 0 (BLINK);
- ph and led_o to all ones.
REQ-026 SHALL discard any partial debounce on rst asserted mid-count, so that no event follows release of rst unless the key is held for a full D+2 cycles afterwards.

Verification (CLK_FREQ=10_000, DEBOUNCE_MS=1, BLINK_MS=2, so D=10 and B=20)
REQ-027 Reset: the bench SHALL check that holding rst for 3 cycles with key=all ones gives led_o all ones and mode_o=0; led_o SHALL then toggle every 20 cycles.
REQ-028 Debounce: the bench SHALL check that a 9-cycle low pulse on key[0] gives no key_evt_o, and that holding key[0] low 50 cycles gives key_evt_o[0] high for exactly 1 cycle, 12 cycles after the first low sample, with mode_o becoming 1 on the next cycle.
REQ-029 Mode wrap: the bench SHALL check that four clean presses of key[0] give mode_o 1,2,3,0, that led_o is all ones in ON and 0 in OFF, and that led_o is all ones immediately on re-entry to BLINK.
REQ-030 Simultaneous: the bench SHALL check that pressing key[0] and key[1] on the same cycle gives both key_evt_o bits pulsed together with mode_o unchanged.
REQ-031 Reset mid-operation: the bench SHALL check that asserting rst 5 cycles into a key[0] hold and releasing it 1 cycle later gives no event until 12 cycles after rst deasserts.
REQ-032 Freeze: the bench SHALL check that pressing key[0] during BLINK while led_o = 0 keeps led_o at 0 for at least 100 cycles.
